// File: rtl/dp_mem_responder.sv
// dp_mem_responder: responder end of the datapath-cache interface.
// It serializes instruction fetches and data reads/writes onto one
// single-ported, variable-latency RAM. Each access ends with a one-cycle
// ihit/dhit pulse. An access that waits too long for ramready is aborted
// and sets a sticky error flag. Once halt is seen, all memory traffic stops.
// Ports:
//   CLK, RST                          clock, async active-high reset
//   imemREN, imemaddr                 fetch request and byte address
//   imemload, ihit                    fetched word and completion pulse
//   dmemREN, dmemWEN, dmemaddr,
//   dmemstore                         data request, address and write data
//   dmemload, dhit                    load data and completion pulse
//   halt                              processor halted
//   ramREN, ramWEN, ramaddr, ramstore RAM request (word-aligned address)
//   ramload, ramready                 RAM read data and completion
//   error                             sticky timeout flag
module dp_mem_responder #(
  parameter int unsigned TIMEOUT = 64,
  parameter logic [31:0] ERRWORD = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic [31:0] imemload,
  output logic        ihit,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic [31:0] dmemload,
  output logic        dhit,
  input  logic        halt,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready,
  output logic        error
);

  localparam int unsigned CW = 16;
  localparam int unsigned AW = 32;

  typedef enum logic [2:0] {IDLE, IACC, DACC, RESP, HALTED} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     store_q, store_d;
  logic            wr_q, wr_d;
  logic [31:0]     imem_load_q, imem_load_d;
  logic [31:0]     dmem_load_q, dmem_load_d;
  logic            ihit_q, ihit_d;
  logic            dhit_q, dhit_d;
  logic            ram_ren_q, ram_ren_d;
  logic            ram_wen_q, ram_wen_d;
  logic            error_q, error_d;

  // State and datapath registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      store_q     <= '0;
      wr_q        <= 1'b0;
      imem_load_q <= '0;
      dmem_load_q <= '0;
      ihit_q      <= 1'b0;
      dhit_q      <= 1'b0;
      ram_ren_q   <= 1'b0;
      ram_wen_q   <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      store_q     <= store_d;
      wr_q        <= wr_d;
      imem_load_q <= imem_load_d;
      dmem_load_q <= dmem_load_d;
      ihit_q      <= ihit_d;
      dhit_q      <= dhit_d;
      ram_ren_q   <= ram_ren_d;
      ram_wen_q   <= ram_wen_d;
      error_q     <= error_d;
    end
  end

  // Next state, launch capture, completion/timeout handling
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    store_d     = store_q;
    wr_d        = wr_q;
    imem_load_d = imem_load_q;
    dmem_load_d = dmem_load_q;
    ihit_d      = 1'b0;
    dhit_d      = 1'b0;
    error_d     = error_q;

    case (state_q)
      IDLE: begin
        if (halt) begin
          state_d = HALTED;
        end else if (dmemREN || dmemWEN) begin
          state_d = DACC;
          addr_d  = dmemaddr;
          store_d = dmemstore;
          wr_d    = dmemWEN;
          cnt_d   = '0;
        end else if (imemREN) begin
          state_d = IACC;
          addr_d  = imemaddr;
          store_d = dmemstore;
          wr_d    = 1'b0;
          cnt_d   = '0;
        end
      end
      IACC, DACC: begin
        if (ramready) begin
          state_d = RESP;
          ihit_d  = (state_q == IACC);
          dhit_d  = (state_q == DACC);
          if (!wr_q) begin
            if (state_q == IACC) imem_load_d = ramload;
            else                 dmem_load_d = ramload;
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // Abort: a read returns the error word, a write returns nothing
          state_d = RESP;
          ihit_d  = (state_q == IACC);
          dhit_d  = (state_q == DACC);
          error_d = 1'b1;
          if (!wr_q) begin
            if (state_q == IACC) imem_load_d = ERRWORD;
            else                 dmem_load_d = ERRWORD;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        state_d = halt ? HALTED : IDLE;
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Strobes follow the next state so they are glitch-free flop outputs
    ram_ren_d = (state_d == IACC) || ((state_d == DACC) && !wr_d);
    ram_wen_d = (state_d == DACC) && wr_d;
  end

  assign imemload = imem_load_q;
  assign dmemload = dmem_load_q;
  assign ihit     = ihit_q;
  assign dhit     = dhit_q;
  assign ramREN   = ram_ren_q;
  assign ramWEN   = ram_wen_q;
  assign ramaddr  = addr_q & ~AW'(3);
  assign ramstore = store_q;
  assign error    = error_q;

endmodule

// File: tb/tb_dp_mem_responder.sv
module tb_dp_mem_responder;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] imemload;
  logic        ihit;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic [31:0] dmemload;
  logic        dhit;
  logic        halt;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ramready;
  logic        error;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit        is_d;
    bit [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  // RAM model knobs
  int          nwait;
  int          wcnt;
  bit          rdy_en;
  bit          force_rdy;

  dp_mem_responder #(.TIMEOUT(4), .ERRWORD(32'hBAD1BAD1)) dut (
    .CLK(CLK), .RST(RST),
    .imemREN(imemREN), .imemaddr(imemaddr), .imemload(imemload), .ihit(ihit),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .dmemload(dmemload), .dhit(dhit),
    .halt(halt),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready), .error(error)
  );

  always #5 CLK = ~CLK;

  // Wait-state RAM model: ready after nwait strobed cycles
  always @(posedge CLK or posedge RST) begin
    if (RST) wcnt <= 0;
    else if ((ramREN || ramWEN) && !ramready) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end
  assign ramready = force_rdy || (rdy_en && (ramREN || ramWEN) && (wcnt >= nwait));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ihit"}, 32'(ihit), 0);
    check({tag, "_dhit"}, 32'(dhit), 0);
    check({tag, "_imemload"}, imemload, 0);
    check({tag, "_dmemload"}, dmemload, 0);
    check({tag, "_ramREN"}, 32'(ramREN), 0);
    check({tag, "_ramWEN"}, 32'(ramWEN), 0);
    check({tag, "_ramaddr"}, ramaddr, 0);
    check({tag, "_ramstore"}, ramstore, 0);
    check({tag, "_error"}, 32'(error), 0);
  endtask

  // Monitor: every hit must match the oldest expected response
  always @(negedge CLK) begin
    if (ihit || dhit) begin
      if (exp_q.size() == 0) begin
        check("unexpected_hit", {30'd0, ihit, dhit}, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("hit_kind", {30'd0, ihit, dhit}, e.is_d ? 32'd1 : 32'd2);
        check("hit_data", e.is_d ? dmemload : imemload, e.data);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; imemREN = 0; imemaddr = 0; dmemREN = 0; dmemWEN = 0;
    dmemaddr = 0; dmemstore = 0; halt = 0; ramload = 0;
    nwait = 0; rdy_en = 1; force_rdy = 0;
    #2;
    check_zero_outputs("reset");
    tick(); tick();
    RST = 1'b0;
    tick();

    // Zero-wait fetch
    ramload = 32'h8C220004;
    imemREN = 1; imemaddr = 32'h6;
    exp_q.push_back('{1'b0, 32'h8C220004});
    tick();
    check("f0_ramREN", 32'(ramREN), 1);
    check("f0_ramWEN", 32'(ramWEN), 0);
    check("f0_ramaddr", ramaddr, 32'h4);
    tick();
    check("f0_ihit", 32'(ihit), 1);
    tick();
    check("f0_ihit_low", 32'(ihit), 0);
    check("f0_no_refetch", 32'(ramREN), 0);
    imemREN = 0;
    tick();

    // Priority and write with 3 wait states, fetch queued behind it
    nwait = 3; ramload = 32'h12345678;
    imemREN = 1; dmemWEN = 1; dmemaddr = 32'h100; dmemstore = 32'hDEADBEEF;
    exp_q.push_back('{1'b1, 32'h0});
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) begin dmemWEN = 0; nwait = 3; end
      check("wr_ramWEN", 32'(ramWEN), 1);
      check("wr_ramREN", 32'(ramREN), 0);
      check("wr_ramaddr", ramaddr, 32'h100);
      check("wr_ramstore", ramstore, 32'hDEADBEEF);
    end
    nwait = 0;
    tick();
    check("wr_dhit", 32'(dhit), 1);
    exp_q.push_back('{1'b0, 32'h12345678});
    tick();
    check("wr_idle_noREN", 32'(ramREN), 0);
    tick();
    check("fq_ramREN", 32'(ramREN), 1);
    check("fq_ramaddr", ramaddr, 32'h4);
    imemREN = 0;
    tick();
    check("fq_ihit", 32'(ihit), 1);
    tick();

    // Timeout on a data read
    rdy_en = 0; dmemREN = 1; dmemaddr = 32'h200;
    exp_q.push_back('{1'b1, 32'hBAD1BAD1});
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) dmemREN = 0;
      check("to_ramREN", 32'(ramREN), 1);
      check("to_error_pre", 32'(error), 0);
    end
    tick();
    check("to_dhit", 32'(dhit), 1);
    check("to_error", 32'(error), 1);
    rdy_en = 1; nwait = 0; ramload = 32'hA5A5A5A5;
    tick();
    dmemREN = 1; dmemaddr = 32'h204;
    exp_q.push_back('{1'b1, 32'hA5A5A5A5});
    tick();
    dmemREN = 0;
    tick();
    check("to_good_dhit", 32'(dhit), 1);
    tick();
    check("to_error_sticky", 32'(error), 1);

    // Halt mid-access
    nwait = 2; ramload = 32'h0F0F0F0F; dmemREN = 1; dmemaddr = 32'h300;
    exp_q.push_back('{1'b1, 32'h0F0F0F0F});
    tick();
    dmemREN = 0; halt = 1; imemREN = 1;
    check("h_ramREN", 32'(ramREN), 1);
    tick(); tick(); tick();
    check("h_dhit", 32'(dhit), 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("h_quiet", {30'd0, ramREN, ramWEN}, 0);
    end

    // Reset mid-access, then a stray ramready
    RST = 1; #2; RST = 0; halt = 0; imemREN = 0;
    tick();
    rdy_en = 0; dmemREN = 1; dmemaddr = 32'h400;
    tick();
    check("r_ramREN", 32'(ramREN), 1);
    dmemREN = 0;
    #2 RST = 1;
    #1;
    check_zero_outputs("rmid");
    tick();
    RST = 0; force_rdy = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("r_late_ready_quiet", {28'd0, ihit, dhit, ramREN, ramWEN}, 0);
    end
    force_rdy = 0; rdy_en = 1;
    tick();

    // Withdrawn request completes to the latched address
    nwait = 2; ramload = 32'h11223344; dmemREN = 1; dmemaddr = 32'h504;
    exp_q.push_back('{1'b1, 32'h11223344});
    tick();
    check("w_ramaddr", ramaddr, 32'h504);
    dmemREN = 0; dmemaddr = 32'h999;
    tick();
    check("w_ramaddr_held", ramaddr, 32'h504);
    check("w_ramREN", 32'(ramREN), 1);
    tick();
    tick();
    check("w_dhit", 32'(dhit), 1);
    tick();
    check("w_dhit_once", 32'(dhit), 0);
    tick(); tick();

    check("exp_queue_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
